spi_seq: RTL and testbench

- Sits between the CPU register bus and the spi master's register port.
- Shares the spi master between two requesters:
  - CPU pass-through, for software-driven multi-byte transactions.
  - A hardware read engine that performs complete serial-flash READ transactions (command, 24-bit address, N data bytes) with no CPU involvement, for boot/cache-fill.
- Streams received bytes out one per valid strobe.

---
 rtl/spi_seq.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_spi_seq.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_seq.sv
// spi_seq -- sequencer in front of the spi master's register port.
//
// Shares one spi master between two requesters:
//   * CPU pass-through: while the read engine is idle, the CPU register bus
//     is wired straight through to the spi master.
//   * Hardware read engine: performs a full serial-flash READ transaction
//     (opcode, 24-bit address, N data bytes) without CPU help. Each received
//     byte is streamed out on rd_data with a one-cycle rd_valid strobe.
//
// Build option:
//   SPI_SEQ_FAST_READ_EN  when defined, the engine issues FAST READ (0x0B)
//                         and one extra, uncaptured dummy byte after the
//                         address. When undefined, it issues CMD_READ and
//                         has no dummy phase.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   cpu_*           CPU register bus (addr, data in/out, sel, read, write)
//   cpu_stall       CPU access refused this cycle because the engine is busy
//   req, req_addr,  engine request (held until req_ack), flash byte address,
//   req_len,        byte count (0 means 256),
//   req_sel         spi device select used by the engine
//   req_ack         one-cycle pulse, request accepted
//   rd_valid,       one-cycle pulse with each received byte
//   rd_data
//   done            one-cycle pulse after the transaction is closed
//   spi_*           spi master register port (addr, data in/out, sel,
//                   read, write) and its byte-complete interrupt

module spi_seq #(
   parameter logic [7:0] CMD_READ = 8'h03,
   parameter logic [7:0] DUMMY    = 8'hFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  cpu_addr,
   input  logic [7:0]  cpu_data_in,
   output logic [7:0]  cpu_data_out,
   input  logic [1:0]  cpu_sel,
   input  logic        cpu_read,
   input  logic        cpu_write,
   output logic        cpu_stall,
   input  logic        req,
   input  logic [23:0] req_addr,
   input  logic [7:0]  req_len,
   input  logic [1:0]  req_sel,
   output logic        req_ack,
   output logic        rd_valid,
   output logic [7:0]  rd_data,
   output logic        done,
   output logic [2:0]  spi_addr,
   output logic [7:0]  spi_data_in,
   input  logic [7:0]  spi_data_out,
   output logic [1:0]  spi_sel,
   output logic        spi_read,
   output logic        spi_write,
   input  logic        spi_interrupt
);

`ifdef SPI_SEQ_FAST_READ_EN
   localparam logic [7:0] OPCODE = 8'h0B;
`else
   localparam logic [7:0] OPCODE = CMD_READ;
`endif

   // Strobe states (CMD..DATA, CAP, END) are the cycles in which the
   // corresponding spi access is visible on the port. WAIT follows every
   // write strobe and returns to next_step.
   typedef enum logic [3:0] {
      S_IDLE,
      S_CMD,
      S_A2,
      S_A1,
      S_A0,
      S_DMY,
      S_DATA,
      S_WAIT,
      S_CAP,
      S_END
   } state_t;

   state_t      state;
   state_t      next_step;
   state_t      tgt;
   logic        skip;
   logic        cpu_own;
   logic [8:0]  cnt;
   logic [23:0] addr_q;
   logic [1:0]  sel_q;

   // Engine-side register port values, driven onto spi_* while busy.
   logic [2:0]  eng_addr;
   logic [7:0]  eng_data;
   logic        eng_read;
   logic        eng_write;

   logic        busy;
   logic        cpu_access;
   logic        grant;
   logic        issue;
   logic        stb_write;
   logic        stb_read;
   logic [2:0]  stb_addr;
   logic [7:0]  stb_data;

   assign busy       = (state != S_IDLE);
   assign cpu_access = cpu_read | cpu_write;

   // CPU wins ties, and a CPU that has opened its own transaction (cpu_own)
   // keeps the engine out until it closes it with a read of address 0.
   assign grant   = !reset && (state == S_IDLE) && req && !cpu_own && !cpu_access;
   assign req_ack = grant;

   assign cpu_stall    = busy & cpu_access;
   assign cpu_data_out = spi_data_out;

   // Owner mux: CPU passes straight through whenever the engine is idle.
   assign spi_addr    = busy ? eng_addr  : cpu_addr;
   assign spi_data_in = busy ? eng_data  : cpu_data_in;
   assign spi_sel     = busy ? sel_q     : cpu_sel;
   assign spi_read    = busy ? eng_read  : cpu_read;
   assign spi_write   = busy ? eng_write : cpu_write;

   // Decide whether the next cycle is a strobe cycle, and which one.
   // Only IDLE (grant), WAIT (interrupt seen) and CAP (byte captured)
   // launch a new access; the write-strobe states always fall into WAIT.
   always_comb begin
      issue = 1'b0;
      tgt   = S_IDLE;
      case (state)
         S_IDLE: begin
            if (grant) begin
               issue = 1'b1;
               tgt   = S_CMD;
            end
         end
         S_WAIT: begin
            if (!skip && spi_interrupt) begin
               issue = 1'b1;
               tgt   = next_step;
            end
         end
         S_CAP: begin
            issue = 1'b1;
            tgt   = (cnt == 9'd1) ? S_END : S_DATA;
         end
         default: begin
            issue = 1'b0;
            tgt   = S_IDLE;
         end
      endcase
   end

   // Register-port values for the access being launched.
   always_comb begin
      stb_write = 1'b0;
      stb_read  = 1'b0;
      stb_addr  = 3'd0;
      stb_data  = 8'h00;
      case (tgt)
         S_CMD: begin
            stb_write = 1'b1;
            stb_addr  = 3'd0;
            stb_data  = OPCODE;
         end
         S_A2: begin
            stb_write = 1'b1;
            stb_addr  = 3'd1;
            stb_data  = addr_q[23:16];
         end
         S_A1: begin
            stb_write = 1'b1;
            stb_addr  = 3'd1;
            stb_data  = addr_q[15:8];
         end
         S_A0: begin
            stb_write = 1'b1;
            stb_addr  = 3'd1;
            stb_data  = addr_q[7:0];
         end
         S_DMY, S_DATA: begin
            stb_write = 1'b1;
            stb_addr  = 3'd1;
            stb_data  = DUMMY;
         end
         S_CAP: begin
            stb_read = 1'b1;
            stb_addr = 3'd1;
         end
         S_END: begin
            // Read of address 0 closes the transfer and raises chip select.
            stb_read = 1'b1;
            stb_addr = 3'd0;
         end
         default: begin
            stb_write = 1'b0;
            stb_read  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         next_step <= S_IDLE;
         skip      <= 1'b0;
         cpu_own   <= 1'b0;
         cnt       <= 9'd0;
         addr_q    <= 24'd0;
         sel_q     <= 2'd0;
         eng_addr  <= 3'd0;
         eng_data  <= 8'h00;
         eng_read  <= 1'b0;
         eng_write <= 1'b0;
         rd_valid  <= 1'b0;
         rd_data   <= 8'h00;
         done      <= 1'b0;
      end else begin
         rd_valid  <= 1'b0;
         done      <= 1'b0;
         eng_read  <= 1'b0;
         eng_write <= 1'b0;
         eng_addr  <= 3'd0;
         eng_data  <= 8'h00;

         // Only forwarded (unstalled) CPU accesses move ownership.
         if (!busy) begin
            if (cpu_write && (cpu_addr == 3'd0)) begin
               cpu_own <= 1'b1;
            end else if (cpu_read && (cpu_addr == 3'd0)) begin
               cpu_own <= 1'b0;
            end
         end

         if (issue) begin
            state     <= tgt;
            eng_write <= stb_write;
            eng_read  <= stb_read;
            eng_addr  <= stb_addr;
            eng_data  <= stb_data;
         end

         case (state)
            S_IDLE: begin
               if (grant) begin
                  addr_q <= req_addr;
                  sel_q  <= req_sel;
                  cnt    <= (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
               end
            end
            S_CMD: begin
               state     <= S_WAIT;
               skip      <= 1'b1;
               next_step <= S_A2;
            end
            S_A2: begin
               state     <= S_WAIT;
               skip      <= 1'b1;
               next_step <= S_A1;
            end
            S_A1: begin
               state     <= S_WAIT;
               skip      <= 1'b1;
               next_step <= S_A0;
            end
            S_A0: begin
               state     <= S_WAIT;
               skip      <= 1'b1;
`ifdef SPI_SEQ_FAST_READ_EN
               next_step <= S_DMY;
`else
               next_step <= S_DATA;
`endif
            end
            S_DMY: begin
               state     <= S_WAIT;
               skip      <= 1'b1;
               next_step <= S_DATA;
            end
            S_DATA: begin
               state     <= S_WAIT;
               skip      <= 1'b1;
               next_step <= S_CAP;
            end
            S_WAIT: begin
               // The interrupt flag may still show the previous byte during
               // the first cycle after a strobe, so that cycle is ignored.
               skip <= 1'b0;
            end
            S_CAP: begin
               rd_data  <= spi_data_out;
               rd_valid <= 1'b1;
               cnt      <= cnt - 9'd1;
            end
            S_END: begin
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_seq.sv
// tb_spi_seq -- self-checking bench for spi_seq.
//
// A small spi master model answers the register port: any write starts a
// byte transfer whose interrupt rises a random 2..6 cycles later, reads of
// address 1 pop the next received byte from a FIFO. Expected register-port
// accesses and received bytes are queued when stimulus is issued; a monitor
// pops and compares them as the DUT produces them.
`timescale 1ns/1ps

module tb_spi_seq;

   localparam logic [7:0] DUMMY = 8'hFF;
`ifdef SPI_SEQ_FAST_READ_EN
   localparam logic [7:0] OPC = 8'h0B;
`else
   localparam logic [7:0] OPC = 8'h03;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [2:0]  cpu_addr;
   logic [7:0]  cpu_data_in;
   logic [7:0]  cpu_data_out;
   logic [1:0]  cpu_sel;
   logic        cpu_read;
   logic        cpu_write;
   logic        cpu_stall;
   logic        req;
   logic [23:0] req_addr;
   logic [7:0]  req_len;
   logic [1:0]  req_sel;
   logic        req_ack;
   logic        rd_valid;
   logic [7:0]  rd_data;
   logic        done;
   logic [2:0]  spi_addr;
   logic [7:0]  spi_data_in;
   logic [7:0]  spi_data_out;
   logic [1:0]  spi_sel;
   logic        spi_read;
   logic        spi_write;
   logic        spi_interrupt;

   spi_seq dut (
      .clk           (clk),
      .reset         (reset),
      .cpu_addr      (cpu_addr),
      .cpu_data_in   (cpu_data_in),
      .cpu_data_out  (cpu_data_out),
      .cpu_sel       (cpu_sel),
      .cpu_read      (cpu_read),
      .cpu_write     (cpu_write),
      .cpu_stall     (cpu_stall),
      .req           (req),
      .req_addr      (req_addr),
      .req_len       (req_len),
      .req_sel       (req_sel),
      .req_ack       (req_ack),
      .rd_valid      (rd_valid),
      .rd_data       (rd_data),
      .done          (done),
      .spi_addr      (spi_addr),
      .spi_data_in   (spi_data_in),
      .spi_data_out  (spi_data_out),
      .spi_sel       (spi_sel),
      .spi_read      (spi_read),
      .spi_write     (spi_write),
      .spi_interrupt (spi_interrupt)
   );

   // ---------------- spi master model ----------------
   logic [7:0] rx_mem [0:1023];
   int         rx_wr = 0;
   int         rx_rd = 0;
   logic       int_flag;
   int         cd;

   assign spi_interrupt = int_flag;
   assign spi_data_out  = rx_mem[rx_rd[9:0]];

   always @(posedge clk) begin
      if (reset) begin
         int_flag <= 1'b0;
         cd       <= 0;
         rx_rd    <= rx_wr;
      end else begin
         if (spi_write) begin
            int_flag <= 1'b0;
            cd       <= $urandom_range(2, 6);
         end else if (cd != 0) begin
            cd <= cd - 1;
            if (cd == 1) int_flag <= 1'b1;
         end
         if (spi_read && (spi_addr == 3'd1)) rx_rd <= rx_rd + 1;
      end
   end

   // ---------------- scoreboard ----------------
   // access encoding: {write, addr[2:0], sel[1:0], data[7:0]}; reads carry data 0
   logic [13:0] exp_acc_q[$];
   logic [7:0]  exp_q[$];
   int tests = 0;
   int fails = 0;
   int rd_exp_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name, input logic [31:0] act);
      tests++;
      fails++;
      $display("FAIL %s: got 0x%0h, expected event did not match (cycle %0d)", name, act, cyc);
   endtask

   function automatic logic [31:0] outs_vec();
      return {5'b0, req_ack, rd_valid, rd_data, done, spi_addr, spi_data_in,
              spi_sel, spi_read, spi_write, cpu_stall};
   endfunction

   // Transaction-level expectation for one engine request.
   task automatic push_req_exp(input logic [23:0] a, input logic [7:0] len,
                               input logic [1:0] s, input logic fixed);
      int n;
      logic [7:0] b;
      n = (len == 8'd0) ? 256 : int'(len);
      exp_acc_q.push_back({1'b1, 3'd0, s, OPC});
      exp_acc_q.push_back({1'b1, 3'd1, s, a[23:16]});
      exp_acc_q.push_back({1'b1, 3'd1, s, a[15:8]});
      exp_acc_q.push_back({1'b1, 3'd1, s, a[7:0]});
`ifdef SPI_SEQ_FAST_READ_EN
      exp_acc_q.push_back({1'b1, 3'd1, s, DUMMY});
`endif
      for (int i = 0; i < n; i++) begin
         b = 8'($urandom_range(0, 255));
         if (fixed && i == 0) b = 8'hAA;
         if (fixed && i == 1) b = 8'h55;
         rx_mem[rx_wr[9:0]] = b;
         rx_wr++;
         exp_q.push_back(b);
         rd_exp_total++;
         exp_acc_q.push_back({1'b1, 3'd1, s, DUMMY});
         exp_acc_q.push_back({1'b0, 3'd1, s, 8'h00});
      end
      exp_acc_q.push_back({1'b0, 3'd0, s, 8'h00});
   endtask

   // ---------------- monitor ----------------
   int   rd_seen = 0;
   int   done_cnt = 0;
   int   done_cyc = -1;
   int   rise_cyc = -100;
   logic int_d = 1'b0;

   always @(negedge clk) begin : monitor
      logic [13:0] act;
      logic [13:0] e;
      logic [7:0]  eb;
      if (!reset) begin
         if (spi_read || spi_write) begin
            act = {spi_write, spi_addr, spi_sel, spi_write ? spi_data_in : 8'h00};
            if (exp_acc_q.size() == 0) begin
               fail_now("spi_access_unexpected", 32'(act));
            end else begin
               e = exp_acc_q.pop_front();
               check("spi_access", 32'(act), 32'(e));
            end
         end
         if (spi_interrupt && !int_d) rise_cyc = cyc;
         if (rd_valid) begin
            rd_seen++;
            check("rd_latency", cyc - rise_cyc, 2);
            if (exp_q.size() == 0) begin
               fail_now("rd_unexpected", 32'(rd_data));
            end else begin
               eb = exp_q.pop_front();
               check("rd_data", 32'(rd_data), 32'(eb));
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_rd_drained", exp_q.size(), 0);
         end
      end
      int_d = spi_interrupt;
   end

   // ---------------- driver tasks ----------------
   task automatic drive_req(input logic [23:0] a, input logic [7:0] len,
                            input logic [1:0] s, output int ack_at);
      @(posedge clk); #1;
      req = 1'b1; req_addr = a; req_len = len; req_sel = s;
      ack_at = -1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (req_ack) begin
            ack_at = cyc;
            break;
         end
      end
      if (ack_at < 0) fail_now("req_ack_timeout", 32'(cyc));
      @(posedge clk); #1;
      req = 1'b0;
   endtask

   task automatic wait_done(input int base);
      bit seen = 1'b0;
      for (int i = 0; i < 30000; i++) begin
         @(negedge clk);
         if (done_cnt > base) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) fail_now("done_timeout", 32'(done_cnt));
   endtask

   task automatic cpu_access(input logic w, input logic [2:0] a, input logic [7:0] d,
                             input logic [1:0] s, output int fwd, output int stalls);
      @(posedge clk); #1;
      cpu_write = w; cpu_read = !w; cpu_addr = a; cpu_data_in = d; cpu_sel = s;
      stalls = 0;
      fwd = -1;
      for (int i = 0; i < 30000; i++) begin
         @(negedge clk);
         if (!cpu_stall) begin
            fwd = cyc;
            break;
         end
         stalls++;
      end
      if (fwd < 0) fail_now("cpu_stall_timeout", 32'(stalls));
      @(posedge clk); #1;
      cpu_write = 1'b0; cpu_read = 1'b0; cpu_addr = 3'd0; cpu_data_in = 8'h00; cpu_sel = 2'd0;
   endtask

   task automatic run_req(input logic [23:0] a, input logic [7:0] len,
                          input logic [1:0] s, input logic fixed);
      int base_rd, base_done, ack_at, n;
      n = (len == 8'd0) ? 256 : int'(len);
      base_rd = rd_seen;
      base_done = done_cnt;
      push_req_exp(a, len, s, fixed);
      drive_req(a, len, s, ack_at);
      wait_done(base_done);
      check("rd_count", rd_seen - base_rd, n);
      check("done_count", done_cnt - base_done, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int fwd, stalls, ack_at, rd_cyc, nw, base_done;
      logic [23:0] a;
      logic [2:0]  ca;
      logic        cw;

      for (int i = 0; i < 1024; i++) rx_mem[i] = 8'h00;
      reset = 1'b1;
      cpu_addr = 3'd0; cpu_data_in = 8'h00; cpu_sel = 2'd0; cpu_read = 1'b0; cpu_write = 1'b0;
      req = 1'b0; req_addr = 24'd0; req_len = 8'd0; req_sel = 2'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", outs_vec(), 32'd0);
      check("cpu_data_out_pass", 32'(cpu_data_out), 32'(spi_data_out));
      @(posedge clk); #1;
      reset = 1'b0;

      // Directed read: bytes 03/0B, 12, 34, 56, [FF], FF, FF on sel 1.
      run_req(24'h123456, 8'd2, 2'd1, 1'b1);
      // Single byte at address 0.
      run_req(24'h000000, 8'd1, 2'd0, 1'b0);
      // Length 0 means 256 bytes.
      run_req(24'($urandom), 8'd0, 2'($urandom_range(0, 3)), 1'b0);

      // CPU write to address 0 in the same cycle as req: CPU wins and owns.
      @(posedge clk); #1;
      exp_acc_q.push_back({1'b1, 3'd0, 2'd0, 8'h9C});
      cpu_write = 1'b1; cpu_addr = 3'd0; cpu_data_in = 8'h9C; cpu_sel = 2'd0;
      a = 24'($urandom);
      req = 1'b1; req_addr = a; req_len = 8'd3; req_sel = 2'd2;
      @(negedge clk);
      check("tie_no_ack", 32'(req_ack), 32'd0);
      check("tie_cpu_forwarded", 32'(cpu_stall), 32'd0);
      @(posedge clk); #1;
      cpu_write = 1'b0; cpu_data_in = 8'h00;
      ack_at = -1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (req_ack) ack_at = cyc;
      end
      check("own_blocks_req", ack_at, -1);
      exp_acc_q.push_back({1'b0, 3'd0, 2'd0, 8'h00});
      base_done = done_cnt;
      push_req_exp(a, 8'd3, 2'd2, 1'b0);
      @(posedge clk); #1;
      cpu_read = 1'b1; cpu_addr = 3'd0;
      rd_cyc = cyc;
      @(posedge clk); #1;
      cpu_read = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (req_ack) begin
            ack_at = cyc;
            break;
         end
         @(negedge clk);
      end
      check("ack_after_release", ack_at, rd_cyc + 1);
      @(posedge clk); #1;
      req = 1'b0;
      wait_done(base_done);
      check("release_done_count", done_cnt - base_done, 1);

      // CPU write while the engine is busy: stalled, forwarded once done.
      a = 24'($urandom);
      base_done = done_cnt;
      push_req_exp(a, 8'd3, 2'd2, 1'b0);
      drive_req(a, 8'd3, 2'd2, ack_at);
      exp_acc_q.push_back({1'b1, 3'd1, 2'd3, 8'h5A});
      cpu_access(1'b1, 3'd1, 8'h5A, 2'd3, fwd, stalls);
      check("stall_seen", 32'(stalls > 0), 32'd1);
      check("fwd_in_done_cycle", fwd, done_cyc);
      check("stall_done_count", done_cnt - base_done, 1);

      // Reset in the WAIT after the A1 byte aborts with no done.
      a = 24'($urandom);
      push_req_exp(a, 8'd4, 2'd1, 1'b0);
      drive_req(a, 8'd4, 2'd1, ack_at);
      nw = 0;
      for (int i = 0; i < 2000 && nw < 3; i++) begin
         @(negedge clk);
         if (spi_write) nw++;
      end
      check("abort_reached_a1", nw, 3);
      @(posedge clk); #1;
      reset = 1'b1;
      rd_exp_total -= exp_q.size();
      exp_q.delete();
      exp_acc_q.delete();
      base_done = done_cnt;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("abort_outputs", outs_vec(), 32'd0);
      repeat (20) @(negedge clk);
      check("abort_no_done", done_cnt - base_done, 0);
      run_req(24'($urandom), 8'd2, 2'd3, 1'b0);

      // Random mix of idle CPU accesses (addresses 2..7) and engine reads.
      for (int k = 0; k < 6; k++) begin
         cw = 1'($urandom_range(0, 1));
         ca = 3'($urandom_range(2, 7));
         a  = 24'($urandom);
         if (cw) begin
            exp_acc_q.push_back({1'b1, ca, 2'd1, 8'h3C + 8'(k)});
            cpu_access(1'b1, ca, 8'h3C + 8'(k), 2'd1, fwd, stalls);
         end else begin
            exp_acc_q.push_back({1'b0, ca, 2'd2, 8'h00});
            cpu_access(1'b0, ca, 8'h00, 2'd2, fwd, stalls);
         end
         check("idle_cpu_not_stalled", stalls, 0);
         run_req(a, 8'($urandom_range(1, 8)), 2'($urandom_range(0, 3)), 1'b0);
      end

      repeat (10) @(posedge clk);
      check("acc_queue_empty", exp_acc_q.size(), 0);
      check("rd_queue_empty", exp_q.size(), 0);
      check("rd_total", rd_seen, rd_exp_total);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
